// File: rtl/clic_irq_arbiter_pkg.sv
// Shared types and helpers for the CLIC interrupt arbiter.
// Preemption is enabled by defining CLIC_ARB_PREEMPT_EN.
package clic_irq_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2,
        COOL = 2'd3
    } clic_arb_state_e;

    // Widths sized for the largest supported configuration (NumSrc <= 256, LevelWidth <= 16)
    localparam int CLIC_ID_W_MAX  = 8;
    localparam int CLIC_LVL_W_MAX = 16;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef struct packed {
        logic                      valid;
        logic [CLIC_ID_W_MAX-1:0]  id;
        logic [CLIC_LVL_W_MAX-1:0] level;
        logic [1:0]                priv;
    } clic_arb_winner_t;

    function automatic logic [1:0] clic_priv_rank(input logic [1:0] priv);
        case (priv)
            PRIV_M:  return 2'd2;
            PRIV_S:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/clic_irq_arbiter_tree.sv
// Combinational binary max tree over {privilege rank, level}; ties resolve to the lowest index.
module clic_arb_tree
    import clic_irq_arbiter_pkg::*;
#(
    parameter int NumSrc     = 64,
    parameter int LevelWidth = 8
) (
    input  logic [NumSrc-1:0]            elig,
    input  logic [NumSrc*LevelWidth-1:0] level,
    input  logic [NumSrc*2-1:0]          priv,
    output clic_arb_winner_t             winner
);

    localparam int IdWidth = $clog2(NumSrc);
    localparam int Leaves  = 2 ** IdWidth;

    function automatic logic [CLIC_LVL_W_MAX+1:0] arb_key(input clic_arb_winner_t w);
        return {clic_priv_rank(w.priv), w.level};
    endfunction

    // Heap layout: node 0 is the root, leaves start at Leaves-1; the left child always holds lower indices
    always_comb begin
        clic_arb_winner_t node [2*Leaves-1];
        for (int i = 0; i < 2*Leaves-1; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < NumSrc; i++) begin
            node[Leaves-1+i].valid                  = elig[i];
            node[Leaves-1+i].id                     = CLIC_ID_W_MAX'(i);
            node[Leaves-1+i].level[LevelWidth-1:0]  = level[i*LevelWidth +: LevelWidth];
            node[Leaves-1+i].priv                   = priv[2*i +: 2];
        end
        for (int k = Leaves-2; k >= 0; k--) begin
            if (node[2*k+1].valid &&
                (!node[2*k+2].valid || arb_key(node[2*k+1]) >= arb_key(node[2*k+2]))) begin
                node[k] = node[2*k+1];
            end else begin
                node[k] = node[2*k+2];
            end
        end
        winner = node[0];
    end

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC interrupt arbiter: pending capture, winner selection and the one-hot request handshake to id_stage.
// Define CLIC_ARB_PREEMPT_EN to allow withdrawing a held request through the kill handshake.
module clic_irq_arbiter
    import clic_irq_arbiter_pkg::*;
#(
    parameter  int NumSrc     = 64,
    parameter  int LevelWidth = 8,
    localparam int IdWidth    = $clog2(NumSrc)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumSrc-1:0]            src_i,
    input  logic [NumSrc-1:0]            src_trig_i,
    input  logic [NumSrc-1:0]            src_en_i,
    input  logic [NumSrc*LevelWidth-1:0] src_level_i,
    input  logic [NumSrc*2-1:0]          src_priv_i,
    output logic [NumSrc-1:0]            pending_o,
    output logic                         irq_valid_o,
    input  logic                         irq_ready_i,
    output logic [NumSrc-1:0]            irq_onehot_o,
    output logic [IdWidth-1:0]           irq_id_o,
    output logic [LevelWidth-1:0]        irq_level_o,
    output logic [1:0]                   irq_priv_o,
    output logic                         irq_kill_req_o,
    input  logic                         irq_kill_ack_i
);

    clic_arb_state_e     state_q;
    logic [NumSrc-1:0]   pend_q, src_q, pend_d, clr_edge;
    clic_arb_winner_t    winner_d, winner_q;
    logic                valid_q, kill_q, accept;
    logic [NumSrc-1:0]   onehot_q;
    logic [IdWidth-1:0]  id_q;
    logic [LevelWidth-1:0] level_q;
    logic [1:0]          priv_q;

    clic_arb_tree #(
        .NumSrc     (NumSrc),
        .LevelWidth (LevelWidth)
    ) u_tree (
        .elig   (pend_q & src_en_i),
        .level  (src_level_i),
        .priv   (src_priv_i),
        .winner (winner_d)
    );

    // A freshly detected edge beats the clear from an acceptance in the same cycle
    assign accept   = ((state_q == REQ) || (state_q == KILL)) && irq_ready_i;
    assign clr_edge = accept ? onehot_q : '0;
    assign pend_d   = (src_trig_i & ((pend_q & ~clr_edge) | (src_i & ~src_q))) |
                      (~src_trig_i & src_i);

`ifdef CLIC_ARB_PREEMPT_EN
    logic preempt;
    logic unused_bits;
    assign preempt = winner_q.valid &&
                     ({clic_priv_rank(winner_q.priv), winner_q.level[LevelWidth-1:0]} >
                      {clic_priv_rank(priv_q), level_q});
    assign irq_kill_req_o = kill_q;
    assign unused_bits    = ^{winner_q.id, winner_q.level};
`else
    logic unused_bits;
    assign irq_kill_req_o = 1'b0;
    assign unused_bits    = ^{winner_q.id, winner_q.level, irq_kill_ack_i, kill_q};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            src_q    <= '0;
            winner_q <= '0;
            valid_q  <= 1'b0;
            kill_q   <= 1'b0;
            onehot_q <= '0;
            id_q     <= '0;
            level_q  <= '0;
            priv_q   <= '0;
        end else begin
            src_q    <= src_i;
            pend_q   <= pend_d;
            winner_q <= winner_d;
            case (state_q)
                IDLE: begin
                    if (winner_q.valid) begin
                        state_q  <= REQ;
                        valid_q  <= 1'b1;
                        id_q     <= winner_q.id[IdWidth-1:0];
                        level_q  <= winner_q.level[LevelWidth-1:0];
                        priv_q   <= winner_q.priv;
                        onehot_q <= NumSrc'(1) << winner_q.id[IdWidth-1:0];
                    end
                end
                REQ: begin
                    if (irq_ready_i) begin
                        state_q  <= COOL;
                        valid_q  <= 1'b0;
                        onehot_q <= '0;
                        id_q     <= '0;
                        level_q  <= '0;
                        priv_q   <= '0;
                    end
`ifdef CLIC_ARB_PREEMPT_EN
                    else if (preempt) begin
                        state_q <= KILL;
                        kill_q  <= 1'b1;
                    end
`endif
                end
                KILL: begin
                    if (irq_ready_i) begin
                        state_q  <= COOL;
                        valid_q  <= 1'b0;
                        kill_q   <= 1'b0;
                        onehot_q <= '0;
                        id_q     <= '0;
                        level_q  <= '0;
                        priv_q   <= '0;
                    end
`ifdef CLIC_ARB_PREEMPT_EN
                    else if (irq_kill_ack_i) begin
                        state_q  <= IDLE;
                        valid_q  <= 1'b0;
                        kill_q   <= 1'b0;
                        onehot_q <= '0;
                        id_q     <= '0;
                        level_q  <= '0;
                        priv_q   <= '0;
                    end
`endif
                end
                COOL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pending_o    = pend_q;
    assign irq_valid_o  = valid_q;
    assign irq_onehot_o = onehot_q;
    assign irq_id_o     = id_q;
    assign irq_level_o  = level_q;
    assign irq_priv_o   = priv_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Self-checking bench for clic_irq_arbiter: arbitration vectors, handshake corner cases and a randomized model run.
module tb_clic_irq_arbiter;

    localparam int NumSrc     = 64;
    localparam int LevelWidth = 8;
    localparam int IdWidth    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_i;
    logic [NumSrc-1:0]            src_i, src_trig_i, src_en_i;
    logic [NumSrc*LevelWidth-1:0] src_level_i;
    logic [NumSrc*2-1:0]          src_priv_i;
    logic [NumSrc-1:0]            pending_o, irq_onehot_o;
    logic                         irq_valid_o, irq_ready_i, irq_kill_req_o, irq_kill_ack_i;
    logic [IdWidth-1:0]           irq_id_o;
    logic [LevelWidth-1:0]        irq_level_o;
    logic [1:0]                   irq_priv_o;

    logic [7:0] lvl_cfg [NumSrc];
    logic [1:0] prv_cfg [NumSrc];

    int checks = 0;
    int errors = 0;

    clic_irq_arbiter #(.NumSrc(NumSrc), .LevelWidth(LevelWidth)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .src_i          (src_i),
        .src_trig_i     (src_trig_i),
        .src_en_i       (src_en_i),
        .src_level_i    (src_level_i),
        .src_priv_i     (src_priv_i),
        .pending_o      (pending_o),
        .irq_valid_o    (irq_valid_o),
        .irq_ready_i    (irq_ready_i),
        .irq_onehot_o   (irq_onehot_o),
        .irq_id_o       (irq_id_o),
        .irq_level_o    (irq_level_o),
        .irq_priv_o     (irq_priv_o),
        .irq_kill_req_o (irq_kill_req_o),
        .irq_kill_ack_i (irq_kill_ack_i)
    );

    always_comb begin
        for (int i = 0; i < NumSrc; i++) begin
            src_level_i[i*LevelWidth +: LevelWidth] = lvl_cfg[i];
            src_priv_i[2*i +: 2]                    = prv_cfg[i];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] src, input logic ready, input logic ack);
        src_i          = src;
        irq_ready_i    = ready;
        irq_kill_ack_i = ack;
        tick();
    endtask

    task automatic setCfgDefault();
        for (int i = 0; i < NumSrc; i++) begin
            lvl_cfg[i] = '0;
            prv_cfg[i] = '0;
        end
        src_trig_i = '0;
        src_en_i   = '1;
    endtask

    task automatic resetDut();
        rst_i = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        while (!irq_valid_o && n < limit) begin
            tick();
            n++;
        end
        checkOutput("wait_valid", {63'd0, irq_valid_o}, 64'd1);
    endtask

    // Reference model: plain per-source rules, a one-cycle-delayed winner and a handshake phase
    localparam int PH_IDLE = 0, PH_REQ = 1, PH_KILL = 2, PH_COOL = 3;
    logic [63:0] m_pend, m_srcq;
    int m_win, m_phase, m_id;
    bit m_valid, m_kill;

    function automatic int keyOf(input int i);
        int rank;
        rank = (prv_cfg[i] == 2'b11) ? 2 : (prv_cfg[i] == 2'b01) ? 1 : 0;
        return rank * 256 + int'(lvl_cfg[i]);
    endfunction

    function automatic int bestSource(input logic [63:0] elig);
        int best = -1;
        for (int i = 0; i < NumSrc; i++) begin
            if (elig[i] && (best < 0 || keyOf(i) > keyOf(best))) best = i;
        end
        return best;
    endfunction

    task automatic modelReset();
        m_pend = '0; m_srcq = '0; m_win = -1; m_phase = PH_IDLE;
        m_id = 0; m_valid = 0; m_kill = 0;
    endtask

    task automatic modelStep();
        logic [63:0] np;
        bit acc;
        int nw;
        if (rst_i) begin
            modelReset();
            return;
        end
        acc = (m_phase == PH_REQ || m_phase == PH_KILL) && irq_ready_i;
        for (int i = 0; i < NumSrc; i++) begin
            if (src_trig_i[i])
                np[i] = (m_pend[i] && !(acc && m_id == i)) || (src_i[i] && !m_srcq[i]);
            else
                np[i] = src_i[i];
        end
        nw = bestSource(m_pend & src_en_i);
        case (m_phase)
            PH_IDLE: if (m_win >= 0) begin m_phase = PH_REQ; m_id = m_win; m_valid = 1; end
            PH_REQ: begin
                if (irq_ready_i) begin m_phase = PH_COOL; m_valid = 0; end
`ifdef CLIC_ARB_PREEMPT_EN
                else if (m_win >= 0 && keyOf(m_win) > keyOf(m_id)) begin m_phase = PH_KILL; m_kill = 1; end
`endif
            end
            PH_KILL: begin
                if (irq_ready_i) begin m_phase = PH_COOL; m_valid = 0; m_kill = 0; end
                else if (irq_kill_ack_i) begin m_phase = PH_IDLE; m_valid = 0; m_kill = 0; end
            end
            default: m_phase = PH_IDLE;
        endcase
        m_pend = np;
        m_srcq = src_i;
        m_win  = nw;
    endtask

    typedef struct {
        int         a;
        logic [1:0] pa;
        logic [7:0] la;
        int         b;
        logic [1:0] pb;
        logic [7:0] lb;
        int         exp_id;
    } arb_vec_t;

    arb_vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] both;
        int other;
        rst_i = 1'b1; src_i = '0; irq_ready_i = 1'b0; irq_kill_ack_i = 1'b0;
        setCfgDefault();
        resetDut();
        checkOutput("reset_valid", {63'd0, irq_valid_o}, 64'd0);
        checkOutput("reset_pending", pending_o, 64'd0);
        checkOutput("reset_onehot", irq_onehot_o, 64'd0);
        checkOutput("reset_kill", {63'd0, irq_kill_req_o}, 64'd0);

        vecs[0] = '{a: 2,  pa: 2'b11, la: 7,   b: 9,  pb: 2'b11, lb: 7, exp_id: 2};
        vecs[1] = '{a: 4,  pa: 2'b01, la: 200, b: 6,  pb: 2'b11, lb: 1, exp_id: 6};
        vecs[2] = '{a: 10, pa: 2'b00, la: 255, b: 11, pb: 2'b01, lb: 0, exp_id: 11};
        vecs[3] = '{a: 0,  pa: 2'b11, la: 4,   b: 63, pb: 2'b11, lb: 5, exp_id: 63};
        vecs[4] = '{a: 30, pa: 2'b01, la: 9,   b: 20, pb: 2'b01, lb: 9, exp_id: 20};
        vecs[5] = '{a: 1,  pa: 2'b00, la: 3,   b: 2,  pb: 2'b00, lb: 4, exp_id: 2};

        foreach (vecs[v]) begin
            setCfgDefault();
            resetDut();
            lvl_cfg[vecs[v].a] = vecs[v].la; prv_cfg[vecs[v].a] = vecs[v].pa;
            lvl_cfg[vecs[v].b] = vecs[v].lb; prv_cfg[vecs[v].b] = vecs[v].pb;
            both  = (64'd1 << vecs[v].a) | (64'd1 << vecs[v].b);
            other = (vecs[v].exp_id == vecs[v].a) ? vecs[v].b : vecs[v].a;
            applyStimulus(both, 1'b0, 1'b0);
            applyStimulus(both, 1'b0, 1'b0);
            checkOutput("vec_latency_early", {63'd0, irq_valid_o}, 64'd0);
            applyStimulus(both, 1'b0, 1'b0);
            checkOutput("vec_valid", {63'd0, irq_valid_o}, 64'd1);
            checkOutput("vec_id", irq_id_o, vecs[v].exp_id);
            checkOutput("vec_onehot", irq_onehot_o, 64'd1 << vecs[v].exp_id);
            checkOutput("vec_level", irq_level_o, (vecs[v].exp_id == vecs[v].a) ? vecs[v].la : vecs[v].lb);
            checkOutput("vec_priv", irq_priv_o, (vecs[v].exp_id == vecs[v].a) ? vecs[v].pa : vecs[v].pb);
            applyStimulus(64'd1 << other, 1'b1, 1'b0);
            checkOutput("vec_cool", {63'd0, irq_valid_o}, 64'd0);
            applyStimulus(64'd1 << other, 1'b0, 1'b0);
            waitValid(6);
            checkOutput("vec_second_id", irq_id_o, other);
            applyStimulus('0, 1'b1, 1'b0);
        end

        // Edge source latency and acceptance clearing only the accepted edge
        setCfgDefault();
        resetDut();
        src_trig_i[5] = 1'b1; lvl_cfg[5] = 3; prv_cfg[5] = 2'b11;
        src_trig_i[7] = 1'b1; lvl_cfg[7] = 1; prv_cfg[7] = 2'b11;
        applyStimulus(64'hA0, 1'b0, 1'b0);
        checkOutput("edge_pending", pending_o, 64'hA0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("edge_valid_n2", {63'd0, irq_valid_o}, 64'd0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("edge_valid_n3", {63'd0, irq_valid_o}, 64'd1);
        checkOutput("edge_id", irq_id_o, 5);
        checkOutput("edge_onehot", irq_onehot_o, 64'd1 << 5);
        checkOutput("edge_level", irq_level_o, 3);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("edge_cool_valid", {63'd0, irq_valid_o}, 64'd0);
        checkOutput("edge_cleared", pending_o, 64'h80);
        applyStimulus('0, 1'b0, 1'b0);
        waitValid(6);
        checkOutput("edge_next_id", irq_id_o, 7);
        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("edge_all_cleared", pending_o, 64'd0);

        // Synchronous reset while a request is held
        setCfgDefault();
        resetDut();
        lvl_cfg[0] = 4; lvl_cfg[1] = 6;
        applyStimulus(64'h3, 1'b0, 1'b0);
        applyStimulus(64'h3, 1'b0, 1'b0);
        applyStimulus(64'h3, 1'b0, 1'b0);
        checkOutput("rst_pre_valid", {63'd0, irq_valid_o}, 64'd1);
        checkOutput("rst_pre_pending", pending_o, 64'h3);
        rst_i = 1'b1;
        applyStimulus(64'h3, 1'b0, 1'b0);
        checkOutput("rst_valid", {63'd0, irq_valid_o}, 64'd0);
        checkOutput("rst_pending", pending_o, 64'd0);
        checkOutput("rst_onehot", irq_onehot_o, 64'd0);
        checkOutput("rst_id_level", {irq_id_o, irq_level_o, irq_priv_o}, 64'd0);
        rst_i = 1'b0;
        src_trig_i[5] = 1'b1; lvl_cfg[5] = 9;
        applyStimulus(64'd1 << 5, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rst_after_n2", {63'd0, irq_valid_o}, 64'd0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rst_after_n3", {63'd0, irq_valid_o}, 64'd1);
        checkOutput("rst_after_id", irq_id_o, 5);
        applyStimulus('0, 1'b1, 1'b0);

        // Higher-key source arriving while id 1 is held
        setCfgDefault();
        resetDut();
        src_trig_i[1] = 1'b1; lvl_cfg[1] = 2;  prv_cfg[1] = 2'b11;
        lvl_cfg[8] = 10; prv_cfg[8] = 2'b11;
        applyStimulus(64'd1 << 1, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("pre_id1", irq_id_o, 1);
`ifdef CLIC_ARB_PREEMPT_EN
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        checkOutput("kill_early", {63'd0, irq_kill_req_o}, 64'd0);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        checkOutput("kill_req", {63'd0, irq_kill_req_o}, 64'd1);
        checkOutput("kill_held_id", irq_id_o, 1);
        applyStimulus(64'd1 << 8, 1'b0, 1'b1);
        checkOutput("kill_idle_valid", {63'd0, irq_valid_o}, 64'd0);
        checkOutput("kill_idle_req", {63'd0, irq_kill_req_o}, 64'd0);
        checkOutput("kill_pend1", pending_o & 64'h2, 64'h2);
        waitValid(6);
        checkOutput("kill_new_id", irq_id_o, 8);
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b0, 1'b0);
        waitValid(6);
        checkOutput("kill_reissue_id", irq_id_o, 1);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        checkOutput("kill_req2", {63'd0, irq_kill_req_o}, 64'd1);
        applyStimulus(64'd1 << 8, 1'b1, 1'b1);
        checkOutput("kill_accept_valid", {63'd0, irq_valid_o}, 64'd0);
        checkOutput("kill_accept_pend1", pending_o & 64'h2, 64'd0);
`else
        for (int c = 0; c < 6; c++) begin
            applyStimulus(64'd1 << 8, 1'b0, 1'b1);
            checkOutput("nopre_kill", {63'd0, irq_kill_req_o}, 64'd0);
            checkOutput("nopre_held_id", irq_id_o, 1);
        end
        applyStimulus(64'd1 << 8, 1'b1, 1'b0);
        applyStimulus(64'd1 << 8, 1'b0, 1'b0);
        waitValid(6);
        checkOutput("nopre_next_id", irq_id_o, 8);
`endif
        applyStimulus('0, 1'b1, 1'b0);

        // Randomized run against the reference model
        setCfgDefault();
        for (int i = 0; i < NumSrc; i++) begin
            lvl_cfg[i]    = 8'($urandom_range(0, 15));
            prv_cfg[i]    = ($urandom_range(0, 2) == 0) ? 2'b00 : ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            src_trig_i[i] = $urandom_range(0, 1) == 1;
        end
        resetDut();
        modelReset();
        for (int c = 0; c < 2000; c++) begin
            logic [63:0] flips;
            flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) src_en_i = src_en_i ^ ({$urandom, $urandom} & {$urandom, $urandom});
            rst_i = ($urandom_range(0, 299) == 0);
            applyStimulus(src_i ^ flips, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            modelStep();
            checkOutput("rnd_pending", pending_o, m_pend);
            checkOutput("rnd_valid", {63'd0, irq_valid_o}, {63'd0, m_valid});
            checkOutput("rnd_kill", {63'd0, irq_kill_req_o}, {63'd0, m_kill});
            checkOutput("rnd_onehot", irq_onehot_o, m_valid ? (64'd1 << m_id) : 64'd0);
            if (m_valid) begin
                checkOutput("rnd_id", irq_id_o, m_id);
                checkOutput("rnd_level_priv", {irq_level_o, irq_priv_o}, {lvl_cfg[m_id], prv_cfg[m_id]});
            end
        end
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
